// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory side of the 16-bit MIPS lw/sw interface. It accepts one request at a
//   time, waits WAIT_CYCLES extra access cycles, then returns a one-cycle ack.
//   The ack carries read data, or an error flag for a misaligned or
//   out-of-range access. CPU byte addresses are mapped to word index addr[15:1].
//
// Ports
//   clk    in   clock, all state changes on posedge
//   rst_n  in   synchronous reset, active-low
//   req    in   request valid, sampled only in IDLE
//   we     in   1 = write (sw), 0 = read (lw)
//   addr   in   [15:0] byte address
//   wdata  in   [15:0] write data
//   rdata  out  [15:0] read data, valid with ack and held until the next read
//   ack    out  one-cycle completion pulse
//   err    out  with ack: misaligned or out-of-range access
//   busy   out  high from the accept edge until the ack cycle ends
//
// state  | meaning
// IDLE   | waiting for req; operands latched on accept
// ACCESS | counting down the access latency; access performed when cnt hits 0
// DONE   | ack cycle; return to IDLE on the next edge

module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [15:0] mem [DEPTH];
  logic [14:0] word_idx;
  logic        addr_ok;
  logic        mem_we;

  // Operands always come from the latched copies, never from the live inputs.
  assign word_idx = addr_q[15:1];
  assign addr_ok  = !addr_q[0] && (32'(word_idx) < DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = DONE;
          if (!addr_ok) begin
            err_d = 1'b1;
          end else if (we_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[word_idx[AW-1:0]];
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Array is not reset; the rst_n gate stops a reset on the commit edge from
  // writing an aborted transaction.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[word_idx[AW-1:0]] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule
